// File: rtl/regbank_pkg.sv
// Shared sizing defaults and FSM state encoding for the register bank
// access controller.
package regbank_pkg;

  localparam int NREG_DEF = 8;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int WDW_DEF  = 1;
  localparam int RDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SCAN
  } state_e;

endpackage

// File: rtl/regbank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The winner is combinational from the request
// vector; the last-winner pointer only moves when the caller commits a grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       ar_n_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] winner_o
);

  logic last_q;

  always_comb begin
    winner_o = 2'b00;
    case (req_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      // On a tie the port that did not win last time goes first.
      2'b11:   winner_o = last_q ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!ar_n_i) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= winner_o[1];
    end
  end

endmodule

// File: rtl/regbank_ctrl.sv
// Access controller for an external register bank and its read mux: arbitrated
// single-cycle reads/writes from two requesters plus a full-bank scan engine.
module regbank_ctrl
  import regbank_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int WDW  = WDW_DEF,
  parameter int RDW  = RDW_DEF
) (
  input  logic            clk,
  input  logic            ar_n,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [WDW-1:0]  wdata0,
  input  logic [WDW-1:0]  wdata1,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [RDW-1:0]  rdata,
  input  logic            scan_start,
  output logic            scan_busy,
  output logic            scan_valid,
  output logic [AW-1:0]   scan_idx,
  output logic [RDW-1:0]  scan_data,
  output logic            scan_done,
  output logic [NREG-1:0] bank_wen,
  output logic [WDW-1:0]  bank_wdata,
  output logic [AW-1:0]   bank_sel,
  input  logic [RDW-1:0]  bank_rdata
);

  state_e         state_q, state_d;
  logic           we_q, we_d;
  logic [AW-1:0]  sel_q, sel_d;
  logic [WDW-1:0] wdata_q, wdata_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     winner;
  logic           arbUpdate;

  logic [1:0]     gnt_q;
  logic [1:0]     rvalid_q;
  logic [RDW-1:0] rdata_q;
  logic           scanBusy_q;
  logic           scanValid_q;
  logic [AW-1:0]  scanIdx_q;
  logic [RDW-1:0] scanData_q;
  logic           scanDone_q;

  rr_arb2 u_arb (
    .clk_i    (clk),
    .ar_n_i   (ar_n),
    .req_i    (req),
    .update_i (arbUpdate),
    .winner_o (winner)
  );

  // sel_q doubles as the access address and the scan index, so bank_sel
  // naturally holds its last value whenever the bank is not being used.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    arbUpdate = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          sel_d   = '0;
        end else if (|req) begin
          state_d   = ACCESS;
          arbUpdate = 1'b1;
          owner_d   = winner;
          if (winner[1]) begin
            we_d    = we[1];
            sel_d   = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we[0];
            sel_d   = addr0;
            wdata_d = wdata0;
          end
        end
      end
      ACCESS: state_d = IDLE;
      SCAN: begin
        if (sel_q == AW'(NREG - 1)) begin
          state_d = IDLE;
        end else begin
          sel_d = sel_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!ar_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      owner_q <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
    end
  end

  // Read returns and scan strobes trail the bank select by one cycle, which
  // is where the combinational mux output is captured.
  always_ff @(posedge clk) begin
    if (!ar_n) begin
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      scanBusy_q  <= 1'b0;
      scanValid_q <= 1'b0;
      scanIdx_q   <= '0;
      scanData_q  <= '0;
      scanDone_q  <= 1'b0;
    end else begin
      gnt_q       <= arbUpdate ? winner : 2'b00;
      rvalid_q    <= (state_q == ACCESS && !we_q) ? owner_q : 2'b00;
      if (state_q == ACCESS && !we_q) begin
        rdata_q <= bank_rdata;
      end
      scanBusy_q  <= (state_q == SCAN) || (state_d == SCAN);
      scanValid_q <= (state_q == SCAN);
      if (state_q == SCAN) begin
        scanIdx_q  <= sel_q;
        scanData_q <= bank_rdata;
      end
      scanDone_q  <= (state_q == SCAN) && (sel_q == AW'(NREG - 1));
    end
  end

  assign gnt        = gnt_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign scan_busy  = scanBusy_q;
  assign scan_valid = scanValid_q;
  assign scan_idx   = scanIdx_q;
  assign scan_data  = scanData_q;
  assign scan_done  = scanDone_q;

  assign bank_wen   = (state_q == ACCESS && we_q) ? (NREG'(1) << sel_q) : '0;
  assign bank_sel   = sel_q;
  assign bank_wdata = wdata_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Self-checking bench for regbank_ctrl with a small behavioural register bank
// whose entries start at their own index (low two bits).
module tb_regbank_ctrl;
  import regbank_pkg::*;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int WDW  = 1;
  localparam int RDW  = 2;

  logic            clk = 1'b0;
  logic            ar_n;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [AW-1:0]   addr0, addr1;
  logic [WDW-1:0]  wdata0, wdata1;
  logic [1:0]      gnt, rvalid;
  logic [RDW-1:0]  rdata;
  logic            scan_start, scan_busy, scan_valid, scan_done;
  logic [AW-1:0]   scan_idx;
  logic [RDW-1:0]  scan_data;
  logic [NREG-1:0] bank_wen;
  logic [WDW-1:0]  bank_wdata;
  logic [AW-1:0]   bank_sel;
  logic [RDW-1:0]  bank_rdata;

  logic [RDW-1:0]  mem [NREG];
  logic            loadBank;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic            port;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [WDW-1:0]  wdata;
    logic [1:0]      expGnt;
    logic [NREG-1:0] expWen;
    logic [RDW-1:0]  expRdata;
  } vec_t;

  always #5 clk = ~clk;

  regbank_ctrl dut (
    .clk        (clk),
    .ar_n       (ar_n),
    .req        (req),
    .we         (we),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_idx   (scan_idx),
    .scan_data  (scan_data),
    .scan_done  (scan_done),
    .bank_wen   (bank_wen),
    .bank_wdata (bank_wdata),
    .bank_sel   (bank_sel),
    .bank_rdata (bank_rdata)
  );

  // Writes update only the low bit of an entry; the upper bit keeps the preload.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (loadBank) begin
        mem[i] <= RDW'(i);
      end else if (bank_wen[i]) begin
        mem[i][0] <= bank_wdata;
      end
    end
  end

  assign bank_rdata = mem[bank_sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
    testsRun++;
    if (act !== expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expVal);
    end
  endtask

  function automatic vec_t mkVec(input logic port, input logic wr, input logic [AW-1:0] addr,
                                 input logic [WDW-1:0] wdata, input logic [1:0] expGnt,
                                 input logic [NREG-1:0] expWen, input logic [RDW-1:0] expRdata);
    vec_t v;
    v.port = port; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.expGnt = expGnt; v.expWen = expWen; v.expRdata = expRdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int lat;
    lat = 0;
    req = v.port ? 2'b10 : 2'b01;
    if (v.port) begin
      we[1] = v.wr; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      we[0] = v.wr; addr0 = v.addr; wdata0 = v.wdata;
    end
    do begin
      tick();
      lat++;
    end while (gnt == 2'b00 && lat < 20);
    checkOutput("gntLatency", 32'(lat), 32'd1);
    checkOutput("gnt", 32'(gnt), 32'(v.expGnt));
    checkOutput("bankWen", 32'(bank_wen), 32'(v.expWen));
    checkOutput("bankSel", 32'(bank_sel), 32'(v.addr));
    if (v.wr) checkOutput("bankWdata", 32'(bank_wdata), 32'(v.wdata));
    req = 2'b00;
    tick();
    checkOutput("rvalid", 32'(rvalid), v.wr ? 32'd0 : 32'(v.expGnt));
    if (!v.wr) checkOutput("rdata", 32'(rdata), 32'(v.expRdata));
    checkOutput("wenAfterAccess", 32'(bank_wen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    logic [1:0]     tieGnt [8];
    logic [1:0]     tieRv  [8];
    logic [RDW-1:0] tieRd  [8];
    logic [RDW-1:0] expScan [NREG];
    logic [7:0]     pat;

    vecs[0] = mkVec(1'b0, 1'b1, 3'd4, 1'b1, 2'b01, 8'b0001_0000, 2'b00);
    vecs[1] = mkVec(1'b0, 1'b0, 3'd4, 1'b0, 2'b01, 8'b0000_0000, 2'b01);
    vecs[2] = mkVec(1'b1, 1'b1, 3'd6, 1'b0, 2'b10, 8'b0100_0000, 2'b00);
    vecs[3] = mkVec(1'b1, 1'b0, 3'd6, 1'b0, 2'b10, 8'b0000_0000, 2'b10);
    vecs[4] = mkVec(1'b1, 1'b0, 3'd3, 1'b0, 2'b10, 8'b0000_0000, 2'b11);
    vecs[5] = mkVec(1'b0, 1'b1, 3'd0, 1'b1, 2'b01, 8'b0000_0001, 2'b00);
    vecs[6] = mkVec(1'b0, 1'b0, 3'd0, 1'b0, 2'b01, 8'b0000_0000, 2'b01);
    vecs[7] = mkVec(1'b0, 1'b1, 3'd7, 1'b0, 2'b01, 8'b1000_0000, 2'b00);
    vecs[8] = mkVec(1'b1, 1'b0, 3'd7, 1'b0, 2'b10, 8'b0000_0000, 2'b10);

    tieGnt  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    tieRv   = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    tieRd   = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    pat     = 8'b0101_0101;
    expScan = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};

    // Reset held with every request line active.
    ar_n = 1'b0; req = 2'b11; we = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; scan_start = 1'b1; loadBank = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("resetOutputs", 32'({gnt, rvalid, rdata, bank_wen, bank_wdata, bank_sel,
                  scan_valid, scan_idx, scan_data, scan_done, scan_busy}), 32'd0);
    end
    ar_n = 1'b1; req = 2'b00; scan_start = 1'b0; loadBank = 1'b0;
    tick();
    checkOutput("idleAfterReset", 32'({gnt, scan_busy}), 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Both ports request continuously: grants alternate starting with port 0.
    req = 2'b11; we = 2'b00; addr0 = 3'd2; addr1 = 3'd5;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("tieGnt", 32'(gnt), 32'(tieGnt[c]));
      checkOutput("tieRvalid", 32'(rvalid), 32'(tieRv[c]));
      if (tieRv[c] != 2'b00) checkOutput("tieRdata", 32'(rdata), 32'(tieRd[c]));
      if (c == 7) req = 2'b00;
    end

    for (int i = 0; i < NREG; i++)
      applyStimulus(mkVec(1'b0, 1'b1, AW'(i), pat[i], 2'b01, NREG'(1) << i, 2'b00));

    // Full scan: select leads the data strobe by one cycle.
    scan_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) scan_start = 1'b0;
      checkOutput("scanBusy", 32'(scan_busy), 32'(c <= 9));
      if (c <= 8) checkOutput("scanSel", 32'(bank_sel), 32'(c - 1));
      checkOutput("scanValid", 32'(scan_valid), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        checkOutput("scanIdx", 32'(scan_idx), 32'(c - 2));
        checkOutput("scanData", 32'(scan_data), 32'(expScan[c - 2]));
      end
      checkOutput("scanDone", 32'(scan_done), 32'(c == 9));
      checkOutput("scanWen", 32'(bank_wen), 32'd0);
    end

    // Scan beats a simultaneous request; a second start mid-scan is dropped.
    scan_start = 1'b1; req = 2'b10; we = 2'b00; addr1 = 3'd3;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) scan_start = 1'b0;
      if (c == 2) scan_start = 1'b1;
      if (c == 3) scan_start = 1'b0;
      checkOutput("scanReqBusy", 32'(scan_busy), 32'(c <= 9));
      checkOutput("scanReqGnt", 32'(gnt), (c == 10) ? 32'd2 : 32'd0);
      if (c == 10) req = 2'b00;
      if (c == 11) begin
        checkOutput("scanReqRvalid", 32'(rvalid), 32'd2);
        checkOutput("scanReqRdata", 32'(rdata), 32'(2'b10));
      end
    end

    // Port 0 wins last so that a reset-restored pointer is observable below.
    applyStimulus(mkVec(1'b0, 1'b0, 3'd2, 1'b0, 2'b01, 8'b0000_0000, 2'b11));

    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("midScanIdx", 32'({scan_valid, scan_idx}), 32'({1'b1, 3'd3}));
    ar_n = 1'b0;
    tick();
    checkOutput("midScanReset", 32'({gnt, rvalid, rdata, bank_wen, bank_wdata, bank_sel,
                scan_valid, scan_idx, scan_data, scan_done, scan_busy}), 32'd0);
    ar_n = 1'b1; req = 2'b11; we = 2'b00; addr0 = 3'd6; addr1 = 3'd1;
    tick();
    checkOutput("postResetGnt", 32'(gnt), 32'd1);
    checkOutput("postResetSel", 32'(bank_sel), 32'd6);
    req = 2'b00;
    tick();
    checkOutput("postResetRvalid", 32'(rvalid), 32'd1);
    checkOutput("postResetRdata", 32'(rdata), 32'(2'b11));
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
